ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 178 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (inhibit, start, 8 data, odd parity, stop, ACK).
// Define PS2_TX_TIMEOUT_EN to add the device-clock watchdog.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       done,
    output logic       err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_XFER,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       clk_sync, data_sync;
    logic             clk_prev;
    logic             clk_s, data_s, fe;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [3:0]       n_q, n_d;
    logic [2:0]       bit_idx;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             ack_ok_q, ack_ok_d;
    logic             done_q, done_d, err_q, err_d;
    logic             clk_oe, data_oe;

    assign clk_s   = clk_sync[1];
    assign data_s  = data_sync[1];
    assign fe      = clk_prev & ~clk_s;
    assign bit_idx = 3'(n_q - 4'd1);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            wd_active, wd_expired;

    assign wd_active  = (state_q == S_XFER) || (state_q == S_ACK) || (state_q == S_RELEASE);
    assign wd_expired = wd_active && !fe && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Cleared on every device edge and outside the device-clocked states (covers XFER entry).
    always_ff @(posedge CLK) begin
        if (!RST_N || fe || !wd_active) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
            inh_q     <= '0;
            n_q       <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            ack_ok_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_sync  <= {clk_sync[0], PS2_CLK_IN};
            data_sync <= {data_sync[0], PS2_DATA_IN};
            clk_prev  <= clk_s;
            inh_q     <= inh_d;
            n_q       <= n_d;
            ack_ok_q  <= ack_ok_d;
            done_q    <= done_d;
            err_q     <= err_d;
            if (state_q == S_IDLE && tx_valid) begin
                data_q   <= tx_data;
                parity_q <= ~^tx_data;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        inh_d    = inh_q;
        n_d      = n_q;
        ack_ok_d = ack_ok_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        clk_oe   = 1'b0;
        data_oe  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    state_d  = S_INHIBIT;
                    inh_d    = '0;
                    n_d      = '0;
                    ack_ok_d = 1'b0;
                end
            end
            S_INHIBIT: begin
                clk_oe = 1'b1;
                if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_d = S_START;
                end else begin
                    inh_d = inh_q + INH_W'(1);
                end
            end
            S_START: begin
                clk_oe  = 1'b1;
                data_oe = 1'b1;
                state_d = S_XFER;
            end
            S_XFER: begin
                // n counts device falling edges seen; the line shows the bit due after edge n.
                if (n_q == 4'd0) begin
                    data_oe = 1'b1;
                end else if (n_q == 4'd9) begin
                    data_oe = ~parity_q;
                end else begin
                    data_oe = ~data_q[bit_idx];
                end
                if (fe) begin
                    n_d = n_q + 4'd1;
                    if (n_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (fe) begin
                    state_d  = S_RELEASE;
                    ack_ok_d = ~data_s;
                    err_d    = data_s;
                end
            end
            S_RELEASE: begin
                if (clk_s && data_s) begin
                    state_d = S_IDLE;
                    done_d  = ack_ok_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef PS2_TX_TIMEOUT_EN
        if (wd_expired) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
`endif
    end

    assign tx_ready    = (state_q == S_IDLE);
    assign PS2_CLK_OE  = clk_oe;
    assign PS2_DATA_OE = data_oe;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 300;
    localparam int HALF = 6;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       PS2_CLK_OE, PS2_DATA_OE;
    logic       done, err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = dev_clk & ~PS2_CLK_OE;
    assign ps2_data = dev_data & ~PS2_DATA_OE;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .PS2_CLK_IN (ps2_clk),
        .PS2_DATA_IN(ps2_data),
        .PS2_CLK_OE (PS2_CLK_OE),
        .PS2_DATA_OE(PS2_DATA_OE),
        .done       (done),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_done;
        bit          chk_bits;
        logic [10:0] bits;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] obs_bits = '0;
    int          checks = 0;
    int          errors = 0;
    int          inh_run = 0;
    int          last_inh = 0;
    bit          done_prev = 1'b0;
    bit          err_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, want);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && (done || err)) begin
            check("done_err_exclusive", 32'(done & err), 32'd0);
            check("pulse_one_cycle", 32'((done & done_prev) | (err & err_prev)), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_outcome done=%0b err=%0b expected no pulse", done, err);
            end else begin
                e = exp_q.pop_front();
                check("outcome_is_done", 32'(done), 32'(e.is_done));
                if (e.chk_bits) check("frame_bits", 32'(obs_bits), 32'(e.bits));
            end
        end
        done_prev = done;
        err_prev  = err;
        if (PS2_CLK_OE) begin
            inh_run++;
        end else if (inh_run != 0) begin
            last_inh = inh_run;
            inh_run  = 0;
        end
    end

    task automatic push_exp(input bit is_done, input bit chk_bits, input logic [10:0] bits);
        exp_t e;
        e.is_done  = is_done;
        e.chk_bits = chk_bits;
        e.bits     = bits;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout got=0 expected=1");
        end
        @(negedge CLK);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
    endtask

    // Device side: samples the line just before each falling edge; nfe<11 leaves the clock low.
    task automatic dev_frame(input int nfe, input bit ack_low);
        int t = 0;
        while (PS2_CLK_OE && t < INH + 50) begin
            @(negedge CLK);
            t++;
        end
        if (PS2_CLK_OE) begin
            checks++;
            errors++;
            $display("FAIL clk_release_timeout got=1 expected=0");
        end
        repeat (4) @(negedge CLK);
        for (int i = 0; i < nfe; i++) begin
            repeat (HALF) @(negedge CLK);
            obs_bits[i] = ps2_data;
            if (i == 10) begin
                dev_data = ack_low ? 1'b0 : 1'b1;
                repeat (3) @(negedge CLK);
            end
            dev_clk = 1'b0;
            if (i < nfe - 1 || nfe == 11) begin
                repeat (HALF) @(negedge CLK);
                dev_clk = 1'b1;
            end
        end
        if (nfe == 11) begin
            repeat (2) @(negedge CLK);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_outcome(input int bound);
        int t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(negedge CLK);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outcome_timeout pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_clk_oe", 32'(PS2_CLK_OE), 32'd0);
        check("rst_data_oe", 32'(PS2_DATA_OE), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // 8'hED: start 0, d0..d7 = 1,0,1,1,0,1,1,1, parity 1, stop 1; stray request mid-frame.
        push_exp(1'b1, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
        send(8'hED);
        fork
            dev_frame(11, 1'b1);
            begin
                repeat (INH + 40) @(negedge CLK);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                @(negedge CLK);
                tx_valid = 1'b0;
            end
        join
        wait_outcome(200);
        check("inhibit_len_ed", 32'(last_inh), 32'(INH + 1));
        repeat (20) @(negedge CLK);
        check("no_queued_frame_clk_oe", 32'(PS2_CLK_OE), 32'd0);
        check("idle_tx_ready", 32'(tx_ready), 32'd1);

        // 8'hF4: five ones, parity 0.
        push_exp(1'b1, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0});
        send(8'hF4);
        dev_frame(11, 1'b1);
        wait_outcome(200);
        check("inhibit_len_f4", 32'(last_inh), 32'(INH + 1));

        // Device never acknowledges: 8'hFF, parity 1.
        push_exp(1'b0, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0});
        send(8'hFF);
        dev_frame(11, 1'b0);
        wait_outcome(200);
        repeat (5) @(negedge CLK);
        check("nack_back_idle", 32'(tx_ready), 32'd1);
        check("nack_data_oe", 32'(PS2_DATA_OE), 32'd0);

        // Reset after the sixth device edge, then a clean resend.
        send(8'hED);
        dev_frame(6, 1'b1);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check("midrst_clk_oe", 32'(PS2_CLK_OE), 32'd0);
        check("midrst_data_oe", 32'(PS2_DATA_OE), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        check("midrst_no_pulse", 32'(done | err), 32'd0);
        RST_N   = 1'b1;
        dev_clk = 1'b1;
        repeat (10) @(negedge CLK);
        push_exp(1'b1, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
        send(8'hED);
        dev_frame(11, 1'b1);
        wait_outcome(200);

`ifdef PS2_TX_TIMEOUT_EN
        push_exp(1'b0, 1'b0, 11'h000);
        send(8'hA5);
        dev_frame(4, 1'b1);
        wait_outcome(TMO + 100);
        check("timeout_clk_oe", 32'(PS2_CLK_OE), 32'd0);
        check("timeout_data_oe", 32'(PS2_DATA_OE), 32'd0);
        dev_clk = 1'b1;
        repeat (10) @(negedge CLK);
`endif

        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
